// File: rtl/dm_arbiter_pkg.sv
// Shared types, constants and helpers for the data-memory arbiter.
package dm_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    DMA_PRI   = 2'd1,
    DMA_BURST = 2'd2
  } arb_state_e;

  // Data memory depth in 32-bit words
  localparam int unsigned DM_WORDS = 3072;

  // One requester's access as seen by the DM port
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  // Expand each byte enable into a full byte lane of ones
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // A byte address is legal when its word index lies inside the DM
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and DM-port signal bundle for the data-memory arbiter.
interface dm_arbiter_if;

  // CPU M-stage requester
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_pc;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  // DMA / debug loader requester
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_be;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  // Single-port data memory
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, cpu_pc,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_be, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output dm_we, dm_addr, dm_wd, dm_pc,
    input  dm_rd
  );

  // Requesters plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, cpu_pc,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output dma_req, dma_we, dma_addr, dma_be, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  dm_we, dm_addr, dm_wd, dm_pc,
    output dm_rd
  );

endinterface

// File: rtl/dm_arbiter_be_merge.sv
// Byte-lane merge: enabled lanes come from the store data, the rest from
// the current DM word, so every DM write is a full-word write.
module dm_be_merge
  import dm_arbiter_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] wd
);

  logic [31:0] mask;

  // Single-cycle read-modify-write of the addressed word
  always_comb begin
    mask = be_to_mask(be);
    wd   = (rd & ~mask) | (wdata & mask);
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU priority with DMA anti-starvation and burst
// locking, byte-enable merge, registered load response and range errors.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 8,
  parameter int unsigned DM_WORDS   = dm_arbiter_pkg::DM_WORDS
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = (BURST_MAX > 2) ? $clog2(BURST_MAX) : 1;

  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        dma_err_q, dma_err_d;

  logic        cpu_gnt, dma_gnt, any_gnt;
  acc_t        cpu_acc, dma_acc, sel_acc;
  logic        in_range;
  logic [31:0] merged_wd;
  logic [31:0] load_data;

  assign cpu_acc = '{we: bus.cpu_we, addr: bus.cpu_addr, be: bus.cpu_be, wdata: bus.cpu_wdata};
  assign dma_acc = '{we: bus.dma_we, addr: bus.dma_addr, be: bus.dma_be, wdata: bus.dma_wdata};

  // Grant: the favoured requester wins whenever it asks, the other gets leftovers
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (state_q == CPU_PRI) begin
      cpu_gnt = bus.cpu_req;
      dma_gnt = bus.dma_req & ~bus.cpu_req;
    end else begin
      dma_gnt = bus.dma_req;
      cpu_gnt = bus.cpu_req & ~bus.dma_req;
    end
  end

  assign any_gnt = cpu_gnt | dma_gnt;

  // DM port steering: only the granted access reaches memory
  always_comb begin
    sel_acc = '0;
    if (cpu_gnt) begin
      sel_acc = cpu_acc;
    end else if (dma_gnt) begin
      sel_acc = dma_acc;
    end
  end

  assign in_range = addr_in_range(sel_acc.addr, DM_WORDS);

  dm_be_merge u_merge (
    .rd    (bus.dm_rd),
    .wdata (sel_acc.wdata),
    .be    (sel_acc.be),
    .wd    (merged_wd)
  );

  assign bus.dm_addr   = sel_acc.addr;
  assign bus.dm_we     = any_gnt & sel_acc.we & in_range & (|sel_acc.be);
  assign bus.dm_wd     = merged_wd;
  assign bus.dm_pc     = cpu_gnt ? bus.cpu_pc : 32'b0;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  // Out-of-range loads still complete, but with zero data
  assign load_data = in_range ? bus.dm_rd : 32'b0;

  // Next state: starvation escalation and burst-length limiting
  always_comb begin
    state_d      = CPU_PRI;
    burst_cnt_d  = '0;
    starve_cnt_d = '0;

    if (state_q == CPU_PRI && bus.dma_req && !dma_gnt) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (dma_gnt) begin
      if (bus.dma_lock && burst_cnt_q < BW'(BURST_MAX - 1)) begin
        state_d     = DMA_BURST;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end else if (state_q == CPU_PRI && bus.dma_req
                 && starve_cnt_q == SW'(STARVE_MAX - 1)) begin
      state_d = DMA_PRI;
    end
  end

  // Load response and error pulse, captured at the grant edge
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    cpu_err_d    = cpu_gnt & ~in_range;
    cpu_rdata_d  = cpu_rvalid_d ? load_data : cpu_rdata_q;
    dma_rvalid_d = dma_gnt & ~bus.dma_we;
    dma_err_d    = dma_gnt & ~in_range;
    dma_rdata_d  = dma_rvalid_d ? load_data : dma_rdata_q;
  end

  // FSM, counters and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CPU_PRI;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_err_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      dma_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_err_q    <= cpu_err_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_err    = dma_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios with a response scoreboard.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .STARVE_MAX (4),
    .BURST_MAX  (8),
    .DM_WORDS   (3072)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory model: combinational read, synchronous write
  logic [31:0] mem [0:3071];
  logic [11:0] rd_idx;
  assign rd_idx     = bus.dm_addr[13:2];
  assign bus.dm_rd  = (bus.dm_addr[31:2] < 30'd3072) ? mem[rd_idx] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (bus.dm_we && rd_idx < 12'd3072) mem[rd_idx] <= bus.dm_wd;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int unsigned cyc;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dma_q[$];

  // Expected response lands one cycle after the grant edge
  task automatic push_cpu(input logic rv, input logic er, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1; e.rvalid = rv; e.err = er; e.rdata = d;
    cpu_q.push_back(e);
  endtask

  task automatic push_dma(input logic rv, input logic er, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1; e.rvalid = rv; e.err = er; e.rdata = d;
    dma_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_rvalid || bus.cpu_err) begin
      n_checks++;
      if (cpu_q.size() == 0) begin
        $display("FAIL cpu_resp unexpected at cyc %0d: rvalid=%0b err=%0b rdata=%h",
                 cyc, bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata);
      end else begin
        e = cpu_q.pop_front();
        if (e.cyc != cyc || bus.cpu_rvalid !== e.rvalid || bus.cpu_err !== e.err ||
            (e.rvalid && bus.cpu_rdata !== e.rdata))
          $display("FAIL cpu_resp cyc=%0d rv=%0b err=%0b rdata=%h, expected cyc=%0d rv=%0b err=%0b rdata=%h",
                   cyc, bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata, e.cyc, e.rvalid, e.err, e.rdata);
        else n_pass++;
      end
    end
    if (bus.dma_rvalid || bus.dma_err) begin
      n_checks++;
      if (dma_q.size() == 0) begin
        $display("FAIL dma_resp unexpected at cyc %0d: rvalid=%0b err=%0b rdata=%h",
                 cyc, bus.dma_rvalid, bus.dma_err, bus.dma_rdata);
      end else begin
        e = dma_q.pop_front();
        if (e.cyc != cyc || bus.dma_rvalid !== e.rvalid || bus.dma_err !== e.err ||
            (e.rvalid && bus.dma_rdata !== e.rdata))
          $display("FAIL dma_resp cyc=%0d rv=%0b err=%0b rdata=%h, expected cyc=%0d rv=%0b err=%0b rdata=%h",
                   cyc, bus.dma_rvalid, bus.dma_err, bus.dma_rdata, e.cyc, e.rvalid, e.err, e.rdata);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_be = 0;
    bus.cpu_wdata = 0; bus.cpu_pc = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_be = 0;
    bus.dma_wdata = 0; bus.dma_lock = 0;
  endtask

  task automatic cpu_acc(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_be = be;
    bus.cpu_wdata = d; bus.cpu_pc = 32'h0000_0400;
  endtask

  task automatic dma_acc(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic lock);
    bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_be = be;
    bus.dma_wdata = d; bus.dma_lock = lock;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) tick();
    n_checks++;
    if ({bus.cpu_rvalid, bus.cpu_err, bus.dma_rvalid, bus.dma_err} !== 4'b0)
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.cpu_rvalid, bus.cpu_err, bus.dma_rvalid, bus.dma_err});
    else n_pass++;
    n_checks++;
    if (bus.cpu_rdata !== 32'h0 || bus.dma_rdata !== 32'h0)
      $display("FAIL reset_rdata got cpu=%h dma=%h exp=0", bus.cpu_rdata, bus.dma_rdata);
    else n_pass++;
    n_checks++;
    if (bus.cpu_gnt !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.dm_we !== 1'b0)
      $display("FAIL reset_idle got gnt=%b%b we=%b exp=000", bus.cpu_gnt, bus.dma_gnt, bus.dm_we);
    else n_pass++;
    rst = 0;
    tick();
  endtask

  task automatic test_solo_cpu();
    cpu_acc(1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.dma_gnt !== 1'b0)
      $display("FAIL solo_store_gnt got cpu=%b stall=%b dma=%b exp=1,0,0",
               bus.cpu_gnt, bus.cpu_stall, bus.dma_gnt);
    else n_pass++;
    n_checks++;
    if (bus.dm_we !== 1'b1 || bus.dm_wd !== 32'hDEADBEEF || bus.dm_addr !== 32'h10)
      $display("FAIL solo_store_port got we=%b wd=%h addr=%h exp=1 deadbeef 10",
               bus.dm_we, bus.dm_wd, bus.dm_addr);
    else n_pass++;
    n_checks++;
    if (bus.dm_pc !== 32'h400) $display("FAIL solo_dm_pc got=%h exp=400", bus.dm_pc);
    else n_pass++;
    tick();
    cpu_acc(0, 32'h10, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dm_we !== 1'b0)
      $display("FAIL solo_load got gnt=%b we=%b exp=1 0", bus.cpu_gnt, bus.dm_we);
    else n_pass++;
    push_cpu(1, 0, 32'hDEADBEEF);
    tick();
    idle();
    tick();
  endtask

  task automatic test_byte_store();
    cpu_acc(1, 32'h10, 4'b0010, 32'h0000AA00);
    #1;
    n_checks++;
    if (bus.dm_we !== 1'b1 || bus.dm_wd !== 32'hDEADAAEF)
      $display("FAIL byte_merge got we=%b wd=%h exp=1 deadaaef", bus.dm_we, bus.dm_wd);
    else n_pass++;
    tick();
    cpu_acc(1, 32'h10, 4'b0000, 32'h11111111);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dm_we !== 1'b0)
      $display("FAIL zero_be_store got gnt=%b we=%b exp=1 0", bus.cpu_gnt, bus.dm_we);
    else n_pass++;
    tick();
    cpu_acc(0, 32'h10, 4'h0, 32'h0);
    push_cpu(1, 0, 32'hDEADAAEF);
    tick();
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    cpu_acc(1, 32'h0, 4'hF, 32'h12345678);
    tick();
    cpu_acc(1, 32'h2FFC, 4'hF, 32'hCAFEF00D);
    #1;
    n_checks++;
    if (bus.dm_we !== 1'b1) $display("FAIL last_word_store got we=%b exp=1", bus.dm_we);
    else n_pass++;
    tick();
    cpu_acc(0, 32'hC000, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dm_we !== 1'b0)
      $display("FAIL oor_load got gnt=%b we=%b exp=1 0", bus.cpu_gnt, bus.dm_we);
    else n_pass++;
    push_cpu(1, 1, 32'h0);
    tick();
    cpu_acc(1, 32'hC000, 4'hF, 32'hFFFFFFFF);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dm_we !== 1'b0)
      $display("FAIL oor_store got gnt=%b we=%b exp=1 0", bus.cpu_gnt, bus.dm_we);
    else n_pass++;
    push_cpu(0, 1, 32'h0);
    tick();
    cpu_acc(0, 32'h0, 4'h0, 32'h0);
    push_cpu(1, 0, 32'h12345678);
    tick();
    cpu_acc(0, 32'h2FFC, 4'h0, 32'h0);
    push_cpu(1, 0, 32'hCAFEF00D);
    tick();
    idle();
    dma_acc(0, 32'hFFFFFFFC, 4'h0, 32'h0, 0);
    #1;
    n_checks++;
    if (bus.dma_gnt !== 1'b1 || bus.dm_pc !== 32'h0)
      $display("FAIL dma_oor_gnt got gnt=%b pc=%h exp=1 0", bus.dma_gnt, bus.dm_pc);
    else n_pass++;
    push_dma(1, 1, 32'h0);
    tick();
    idle();
    tick();
  endtask

  task automatic test_starvation();
    logic exp_cpu;
    cpu_acc(0, 32'h10, 4'h0, 32'h0);
    dma_acc(0, 32'h0, 4'h0, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_cpu = (i != 4);
      n_checks++;
      if (bus.cpu_gnt !== exp_cpu || bus.dma_gnt !== !exp_cpu || bus.cpu_stall !== !exp_cpu)
        $display("FAIL starve_cycle%0d got cpu=%b dma=%b stall=%b exp cpu=%b",
                 i + 1, bus.cpu_gnt, bus.dma_gnt, bus.cpu_stall, exp_cpu);
      else n_pass++;
      if (exp_cpu) push_cpu(1, 0, 32'hDEADAAEF);
      else push_dma(1, 0, 32'h12345678);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_burst();
    logic exp_dma;
    int   k;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) cpu_acc(0, 32'h10, 4'h0, 32'h0);
      dma_acc(1, 32'h100 + 4 * k, 4'hF, 32'hA5000000 | k, 1);
      #1;
      exp_dma = (i < 8);
      n_checks++;
      if (bus.dma_gnt !== exp_dma || bus.cpu_gnt !== (!exp_dma))
        $display("FAIL burst_cycle%0d got dma=%b cpu=%b exp dma=%b",
                 i + 1, bus.dma_gnt, bus.cpu_gnt, exp_dma);
      else n_pass++;
      if (exp_dma) k++;
      else push_cpu(1, 0, 32'hDEADAAEF);
      tick();
    end
    n_checks++;
    if (k != 8) $display("FAIL burst_len got=%0d exp=8", k);
    else n_pass++;
    idle();
    tick();
    dma_acc(0, 32'h11C, 4'h0, 32'h0, 0);
    push_dma(1, 0, 32'hA5000007);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    dma_acc(0, 32'h104, 4'h0, 32'h0, 1);
    push_dma(1, 0, 32'hA5000001);
    tick();
    dma_acc(0, 32'h108, 4'h0, 32'h0, 1);
    push_dma(1, 0, 32'hA5000002);
    tick();
    dma_acc(0, 32'h10C, 4'h0, 32'h0, 1);
    rst = 1;
    tick();
    n_checks++;
    if ({bus.cpu_rvalid, bus.cpu_err, bus.dma_rvalid, bus.dma_err} !== 4'b0)
      $display("FAIL midburst_flags got=%b exp=0000",
               {bus.cpu_rvalid, bus.cpu_err, bus.dma_rvalid, bus.dma_err});
    else n_pass++;
    rst = 0;
    cpu_acc(0, 32'h10, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0)
      $display("FAIL midburst_cpu_pri got cpu=%b dma=%b exp=1 0", bus.cpu_gnt, bus.dma_gnt);
    else n_pass++;
    push_cpu(1, 0, 32'hDEADAAEF);
    tick();
    idle();
    dma_acc(0, 32'h100, 4'h0, 32'h0, 0);
    push_dma(1, 0, 32'hA5000000);
    tick();
    idle();
    cpu_acc(0, 32'h0, 4'h0, 32'h0);
    push_cpu(1, 0, 32'h12345678);
    tick();
    idle();
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_solo_cpu();
    test_byte_store();
    test_out_of_range();
    test_starvation();
    test_burst();
    test_reset_mid_burst();
    n_checks++;
    if (cpu_q.size() != 0 || dma_q.size() != 0)
      $display("FAIL missing_responses got cpu=%0d dma=%0d pending exp=0 0",
               cpu_q.size(), dma_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
